modexp_ctrl: RTL and testbench
==============================

# modexp_ctrl

Sequencer that drives one `montgomery` multiplier instance to compute a modular exponentiation, using left-to-right binary square-and-multiply. Operands and result are in the Montgomery domain. The block sits between the top-level RSA interface and the multiplier. It owns the multiplier's start/done handshake and holds its operands for the whole of each multiplication.

## Interface
Parameters:
- `WIDTH`, 1024: modulus and operand width in bits.
- `EXP_WIDTH`, 1024: exponent width in bits; bit counter is `$clog2(EXP_WIDTH)` wide.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `in_x` in WIDTH: base, already in Montgomery form (x·R mod m).
- `in_r` in WIDTH: R mod m, i.e. Montgomery "one".
- `in_e` in EXP_WIDTH: exponent.
- `in_m` in WIDTH: odd modulus.
- `result` out WIDTH: x^e in Montgomery form; held until next accepted start.
- `busy` out 1: high from the cycle after start acceptance until done.
- `done` out 1: one-cycle pulse; result valid in the same cycle.
- `mm_start` out 1: one-cycle start pulse to the multiplier.
- `mm_a`, `mm_b`, `mm_m` out WIDTH: multiplier operands; stable from mm_start until mm_done.
- `mm_result` in WIDTH+1: multiplier output, already reduced below m.
- `mm_done` in 1: multiplier completion pulse.

## Operation
- Registers: `X`, `M`, `E` (captured at start), accumulator `A`, bit index `i`, FSM state.
- States:
  - IDLE: on `start`, capture inputs, set `A<=in_r`, `i<=EXP_WIDTH-1`, go to SCAN.
  - SCAN: evaluate `E[i]`.
    - Normal path: go to SQ_GO.
    - Skip path (macro only, see Configuration): go to NEXT.
  - SQ_GO: `mm_a=mm_b=A`, `mm_start=1` for one cycle, go to SQ_WAIT.
  - SQ_WAIT: on `mm_done`, `A<=mm_result[WIDTH-1:0]`.
    - If `E[i]` is set, go to MUL_GO; otherwise go to NEXT.
  - MUL_GO: `mm_a=A`, `mm_b=X`, `mm_start=1`, go to MUL_WAIT.
  - MUL_WAIT: on `mm_done`, `A<=mm_result[WIDTH-1:0]`, go to NEXT.
  - NEXT: if `i==0`, go to FINISH; else `i<=i-1`, go to SCAN.
  - FINISH: `result<=A`, `done=1`, go to IDLE.
- `mm_m` = `M` at all times after capture.
- `mm_done` is ignored outside the WAIT states.
- `start` is ignored while busy; inputs may change freely after capture.
- Reset, at any time including mid-multiplication:
  - State returns to IDLE.
  - `result`, `mm_a`, `mm_b`, `mm_m`, `A` reset to 0.
  - `busy`, `done`, `mm_start` reset to 0.
  - The multiplier shares `resetn`, so no partial operation survives.
- `mm_result` bit WIDTH is discarded. The multiplier guarantees its output is below m, so no controller-side subtraction is needed.

## Timing
- The start-accept cycle is IDLE; `busy` rises the next cycle.
- Per multiplication:
  - 1 cycle in GO, plus L cycles of WAIT, where `mm_done` arrives L cycles after `mm_start`.
  - `A` updates on the `mm_done` edge.
- Per exponent bit: 1 cycle SCAN + 1 cycle NEXT + multiplications.
- FINISH: 1 cycle. `done` is asserted in FINISH. `busy` falls on the cycle `done` is asserted.
- Total cycles = 2·EXP_WIDTH + 1 + Σ over multiplications (1+L).
- Back-to-back operation is allowed: `start` is accepted in the cycle after FINISH.

## Configuration
- `MODEXP_SKIP_LEADING_ZEROS_EN`
  - Defined:
    - SCAN on a zero bit while `A` is still the initial value (flag `seen_one`=0) issues no multiplication.
    - The first 1 bit sets `A<=X` directly, sets `seen_one`, and issues no multiplication.
    - Subsequent bits follow the normal path.
    - `e=0` issues zero multiplications; result = `in_r`.
  - Undefined: every bit issues a square, and every set bit issues a multiply.
- Results are identical either way; only the multiplication count and latency differ.

## Test plan
Bench uses WIDTH=8, EXP_WIDTH=4, m=13, in_r=9, and a behavioral multiplier (A·B·2⁻⁸ mod 13) with L=5. Each scenario below is run with and without the macro.
- x=2 (in_x=5), e=0101 -> result=2.
  - With macro: 3 `mm_start` pulses.
  - Without macro: 6 pulses.
- e=1111, in_x=5 -> result=7.
  - With macro: 6 pulses.
  - Without macro: 8 pulses.
- e=0000 -> result=9.
  - With macro: 0 pulses.
  - Without macro: 4 squares.
  - `done` is exactly one cycle in both cases.
- `start` pulsed mid-run with different in_e -> ignored; first result unchanged.
  - Multiplier latency randomized 1–20: `mm_a`/`mm_b` stable across every GO→done window.
  - Spurious `mm_done` in SCAN has no effect.
- `resetn` low during MUL_WAIT -> all outputs 0 immediately (asynchronous).
  - After release, a new start with e=0101 -> result=2.

Source files
------------

// File: rtl/modexp_ctrl.sv
// -----------------------------------------------------------------------------
// modexp_ctrl
//
// Purpose:
//   Sequences one Montgomery multiplier to compute x^e mod m with left-to-right
//   binary square-and-multiply. The base, the Montgomery "one" and the result
//   are all in the Montgomery domain.
//
// Ports:
//   clk        in   clock, rising edge
//   resetn     in   asynchronous active-low reset (shared with the multiplier)
//   start      in   one-cycle request, sampled only while idle
//   in_x       in   [WIDTH]     base in Montgomery form
//   in_r       in   [WIDTH]     R mod m (Montgomery one)
//   in_e       in   [EXP_WIDTH] exponent
//   in_m       in   [WIDTH]     odd modulus
//   result     out  [WIDTH]     x^e in Montgomery form, held until next start
//   busy       out  high from the cycle after start acceptance until done
//   done       out  one-cycle pulse, result valid in the same cycle
//   mm_start   out  one-cycle start pulse to the multiplier
//   mm_a/b/m   out  [WIDTH]     multiplier operands, stable start..done
//   mm_result  in   [WIDTH+1]   multiplier output, already below m
//   mm_done    in   multiplier completion pulse
//
// Build option:
//   MODEXP_SKIP_LEADING_ZEROS_EN - when defined, leading zero exponent bits
//   issue no multiplications and the first set bit loads A with X directly.
//   Results are identical; only multiplication count and latency change.
// -----------------------------------------------------------------------------
module modexp_ctrl #(
  parameter int WIDTH     = 1024,
  parameter int EXP_WIDTH = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic                 done,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH:0]       mm_result,
  input  logic                 mm_done
);

  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SQ_GO,
    S_SQ_WAIT,
    S_MUL_GO,
    S_MUL_WAIT,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [IW-1:0]        i_q, i_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     mm_a_q, mm_a_d;
  logic [WIDTH-1:0]     mm_b_q, mm_b_d;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  logic                 seen_one_q, seen_one_d;
`endif

  // The multiplier guarantees its output is already below m.
  logic unused_mm_msb;
  assign unused_mm_msb = mm_result[WIDTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      m_q        <= '0;
      e_q        <= '0;
      a_q        <= '0;
      i_q        <= '0;
      result_q   <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
      seen_one_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      m_q        <= m_d;
      e_q        <= e_d;
      a_q        <= a_d;
      i_q        <= i_d;
      result_q   <= result_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
      seen_one_q <= seen_one_d;
`endif
    end
  end

  // Operands are loaded on the edge that enters a GO state, so they are
  // already valid in the mm_start cycle and held until the WAIT state exits.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    m_d        = m_q;
    e_d        = e_q;
    a_d        = a_q;
    i_d        = i_q;
    result_d   = result_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    seen_one_d = seen_one_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = in_x;
          m_d     = in_m;
          e_d     = in_e;
          a_d     = in_r;
          i_d     = IW'(EXP_WIDTH - 1);
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
          seen_one_d = 1'b0;
`endif
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        if (!seen_one_q) begin
          // While A is still "one", squaring is a no-op and the first
          // multiply would just yield X.
          if (e_q[i_q]) begin
            a_d        = x_q;
            seen_one_d = 1'b1;
          end
          state_d = S_NEXT;
        end else begin
          mm_a_d  = a_q;
          mm_b_d  = a_q;
          state_d = S_SQ_GO;
        end
`else
        mm_a_d  = a_q;
        mm_b_d  = a_q;
        state_d = S_SQ_GO;
`endif
      end
      S_SQ_GO:  state_d = S_SQ_WAIT;
      S_SQ_WAIT: begin
        if (mm_done) begin
          a_d = mm_result[WIDTH-1:0];
          if (e_q[i_q]) begin
            mm_a_d  = mm_result[WIDTH-1:0];
            mm_b_d  = x_q;
            state_d = S_MUL_GO;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_MUL_GO: state_d = S_MUL_WAIT;
      S_MUL_WAIT: begin
        if (mm_done) begin
          a_d     = mm_result[WIDTH-1:0];
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (i_q == '0) begin
          // Loaded here so result is already valid while done is high.
          result_d = a_q;
          state_d  = S_FINISH;
        end else begin
          i_d     = i_q - 1'b1;
          state_d = S_SCAN;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign result   = result_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done     = (state_q == S_FINISH);
  assign mm_start = (state_q == S_SQ_GO) || (state_q == S_MUL_GO);
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = m_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_modexp_ctrl
//
// Purpose:
//   Scoreboard bench for modexp_ctrl with WIDTH=8, EXP_WIDTH=4, m=13, R=256.
//   A behavioural Montgomery multiplier (a*b*R^-1 mod m) with random latency
//   answers the DUT. Expected results come from plain modular exponentiation
//   of the base converted out of the Montgomery domain. Build with or without
//   MODEXP_SKIP_LEADING_ZEROS_EN; the expected multiplication count follows it.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_modexp_ctrl;

  localparam int W   = 8;
  localparam int EW  = 4;
  localparam int MOD = 13;
  localparam int RV  = 256 % MOD;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [W-1:0]  in_x, in_r, in_m;
  logic [EW-1:0] in_e;
  logic [W-1:0]  result;
  logic          busy, done, mm_start;
  logic [W-1:0]  mm_a, mm_b, mm_m;
  logic [W:0]    mm_result;
  logic          mm_done;

  modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .in_x      (in_x),
    .in_r      (in_r),
    .in_e      (in_e),
    .in_m      (in_m),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .mm_start  (mm_start),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_m      (mm_m),
    .mm_result (mm_result),
    .mm_done   (mm_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    int           pulses;
    int           e;
  } exp_t;

  exp_t exp_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;

  // shared between multiplier model, monitor and driver
  int lat_sum   = 0;
  int fixed_lat = 0;
  bit spurious_en = 1'b1;

  function automatic int mont_rinv();
    int r;
    r = 1;
    for (int k = 1; k < MOD; k++)
      if ((RV * k) % MOD == 1) r = k;
    return r;
  endfunction

  // x^e in Montgomery form, via the plain domain.
  function automatic logic [W-1:0] ref_result(input logic [W-1:0] xm, input logic [EW-1:0] e);
    int xp, y;
    xp = (int'(xm) * mont_rinv()) % MOD;
    y  = 1;
    for (int k = 0; k < int'(e); k++) y = (y * xp) % MOD;
    return W'((y * RV) % MOD);
  endfunction

  function automatic int ref_pulses(input logic [EW-1:0] e);
    int pop, msb;
    pop = $countones(e);
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    if (e == '0) return 0;
    msb = 0;
    for (int k = 0; k < EW; k++) if (e[k]) msb = k;
    return msb + pop - 1;
`else
    msb = 0;
    return EW + pop + msb;
`endif
  endfunction

  // Behavioural multiplier: captures operands on mm_start, answers after L
  // cycles, checks operands stay put, and fires stray mm_done when idle.
  initial begin : mult_model
    logic [W-1:0] cap_a, cap_b, cap_m;
    int cnt, lat, prod;
    bit active;
    active    = 1'b0;
    cnt       = 0;
    lat       = 1;
    mm_done   = 1'b0;
    mm_result = '0;
    forever begin
      @(posedge clk);
      #1;
      mm_done = 1'b0;
      if (!resetn) begin
        active = 1'b0;
      end else if (active) begin
        cnt++;
        vec_cnt++;
        if ({mm_a, mm_b, mm_m} !== {cap_a, cap_b, cap_m}) begin
          err_cnt++;
          $display("FAIL operand_hold: a=%0d b=%0d m=%0d, required a=%0d b=%0d m=%0d",
                   mm_a, mm_b, mm_m, cap_a, cap_b, cap_m);
        end
        if (cnt >= lat) begin
          prod      = (int'(cap_a) * int'(cap_b) * mont_rinv()) % MOD;
          mm_result = {1'($urandom_range(0, 1)), W'(prod)};
          mm_done   = 1'b1;
          active    = 1'b0;
        end
      end else if (mm_start) begin
        cap_a = mm_a;
        cap_b = mm_b;
        cap_m = mm_m;
        vec_cnt++;
        if (mm_m !== W'(MOD)) begin
          err_cnt++;
          $display("FAIL mm_m: got %0d, required %0d", mm_m, MOD);
        end
        lat     = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 20));
        lat_sum = lat_sum + 1 + lat;
        cnt     = 0;
        active  = 1'b1;
      end else if (spurious_en && $urandom_range(0, 3) == 0) begin
        mm_result = 9'($urandom);
        mm_done   = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every done pulse.
  initial begin : monitor
    int  pulse_cnt, busy_cnt;
    bit  prev_done;
    exp_t t;
    pulse_cnt = 0;
    busy_cnt  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pulse_cnt = 0;
        busy_cnt  = 0;
        lat_sum   = 0;
        prev_done = 1'b0;
      end else begin
        if (prev_done) begin
          vec_cnt++;
          if (done) begin
            err_cnt++;
            $display("FAIL done_width: done high %0d cycles in a row, required 1", 2);
          end
        end
        if (mm_start) pulse_cnt++;
        if (busy) busy_cnt++;
        if (done) begin
          vec_cnt++;
          if (busy) begin
            err_cnt++;
            $display("FAIL busy_at_done: busy=%0b, required 0", busy);
          end
          vec_cnt++;
          if (exp_q.size() == 0) begin
            err_cnt++;
            $display("FAIL unexpected_done: result=%0d with nothing outstanding", result);
          end else begin
            t = exp_q.pop_front();
            $display("txn e=%0d result=%0d exp=%0d pulses=%0d exp=%0d busy_cycles=%0d exp=%0d",
                     t.e, result, t.res, pulse_cnt, t.pulses, busy_cnt, 2 * EW + lat_sum);
            if (result !== t.res) begin
              err_cnt++;
              $display("FAIL result: got %0d, required %0d", result, t.res);
            end
            vec_cnt++;
            if (pulse_cnt != t.pulses) begin
              err_cnt++;
              $display("FAIL mm_start_count: got %0d, required %0d", pulse_cnt, t.pulses);
            end
            vec_cnt++;
            if (busy_cnt != 2 * EW + lat_sum) begin
              err_cnt++;
              $display("FAIL busy_cycles: got %0d, required %0d", busy_cnt, 2 * EW + lat_sum);
            end
          end
          pulse_cnt = 0;
          busy_cnt  = 0;
          lat_sum   = 0;
        end
        prev_done = done;
      end
    end
  end

  // Issue one operation and wait (bounded) for its done pulse.
  task automatic run_op(input logic [EW-1:0] e, input logic [W-1:0] x, input bit stray);
    exp_t t;
    bit   got;
    int   stray_at;
    t.res    = ref_result(x, e);
    t.pulses = ref_pulses(e);
    t.e      = int'(e);
    @(negedge clk);
    in_x  = x;
    in_r  = W'(RV);
    in_m  = W'(MOD);
    in_e  = e;
    start = 1'b1;
    exp_q.push_back(t);
    @(negedge clk);
    start = 1'b0;
    in_x  = 8'($urandom);
    in_r  = 8'($urandom);
    in_m  = 8'($urandom);
    in_e  = 4'($urandom);
    stray_at = $urandom_range(0, 40);
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (stray && c == stray_at && busy) begin
        start = 1'b1;
        in_e  = ~e;
        in_x  = x + 8'd1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    vec_cnt++;
    if (!got) begin
      err_cnt++;
      $display("FAIL done_timeout: no done within %0d cycles, required done", 3000);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time exhausted, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int  k;
    bit  got;
    resetn = 1'b1;
    start  = 1'b0;
    in_x   = '0;
    in_r   = '0;
    in_m   = '0;
    in_e   = '0;
    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if ({result, mm_a, mm_b, mm_m, busy, done, mm_start} !== '0) begin
      err_cnt++;
      $display("FAIL reset_state: result=%0d a=%0d b=%0d m=%0d busy=%0b done=%0b start=%0b, required all 0",
               result, mm_a, mm_b, mm_m, busy, done, mm_start);
    end
    resetn = 1'b1;

    // directed scenarios
    run_op(4'b0101, 8'd5, 1'b0);
    run_op(4'b1111, 8'd5, 1'b0);
    run_op(4'b0000, 8'($urandom_range(0, MOD - 1)), 1'b0);
    run_op(4'b0101, 8'd5, 1'b1);
    run_op(4'b1111, 8'd5, 1'b1);

    // reset during the multiply of e=0101 (third multiplier op either way)
    fixed_lat = 10;
    @(negedge clk);
    in_x = 8'd5; in_r = W'(RV); in_m = W'(MOD); in_e = 4'b0101;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (mm_start) k++;
      if (k == 3) begin
        got = 1'b1;
        break;
      end
    end
    vec_cnt++;
    if (!got) begin
      err_cnt++;
      $display("FAIL mul_wait_timeout: saw %0d mm_start pulses, required 3", k);
    end
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    vec_cnt++;
    if ({result, mm_a, mm_b, mm_m, busy, done, mm_start} !== '0) begin
      err_cnt++;
      $display("FAIL async_reset: result=%0d a=%0d b=%0d m=%0d busy=%0b done=%0b start=%0b, required all 0",
               result, mm_a, mm_b, mm_m, busy, done, mm_start);
    end
    exp_q.delete();
    fixed_lat = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    run_op(4'b0101, 8'd5, 1'b0);

    // randomized operations, back to back
    for (int n = 0; n < 20; n++) begin
      run_op(4'($urandom), 8'($urandom_range(0, MOD - 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drain: %0d outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
